seq_scan_ctrl: RTL and testbench
================================

Name: seq_scan_ctrl

Overview:
- Sequencing controller for the serial pattern-detection path.
- Accepts a parallel word with a start handshake, then serialises it MSB-first, one bit per clock.
- Runs each bit through a programmable PAT_W-bit Moore-style pattern matcher, counting matches and recording the first match position.
- Sits between a register/host interface and the serial detector datapath; replaces hand-driven bench stimulus with a self-timed scan.

Parameters:
- DATA_W, 16: width of the scanned word.
- PAT_W, 4: pattern length. Elaboration error if PAT_W < 2 or PAT_W > DATA_W.
- CNT_W, $clog2(DATA_W+1): width of the count and position outputs.

Ports:
- clock  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low (0 = reset); clears all state immediately.
- start  in  1  request a scan; sampled only in IDLE.
- data_in  in  DATA_W  word to scan; captured on the accepted start.
- pattern  in  PAT_W  target pattern, MSB = first bit in time; captured on the accepted start.
- overlap  in  1  1 = overlapping matches counted; 0 = non-overlapping. Captured on the accepted start.
- busy  out  1  high while bits are being presented (SHIFT state).
- bit_out  out  1  serial bit currently presented.
- bit_valid  out  1  bit_out is valid (equals busy).
- match  out  1  one-cycle pulse per detected match.
- done  out  1  one-cycle pulse at the end of a scan.
- found  out  1  at least one match in the last scan.
- match_count  out  CNT_W  number of matches in the last scan.
- first_pos  out  CNT_W  0-based index of the bit that completed the first match; 0 if found = 0.

Behaviour:
- Reset: state = IDLE; all outputs 0; shift, history, fill and index registers 0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start = 1 at an edge captures data_in, pattern and overlap.
  - The same edge clears match_count, first_pos, found, history, fill counter and index; next state = SHIFT.
- SHIFT:
  - busy = bit_valid = 1; bit_out = shift register MSB.
  - Each edge: shift register shifts left; history <= {history[PAT_W-2:0], bit_out}; fill saturates at PAT_W-1; idx increments.
- Match rule (combinational): fill == PAT_W-1 and {history[PAT_W-2:0], bit_out} == pattern.
- On a match edge:
  - match is registered high for the following cycle; match_count increments.
  - If found = 0: first_pos <= idx and found <= 1.
  - If overlap = 0: fill and history clear, so the next match needs PAT_W fresh bits.
- SHIFT exit: the edge consuming idx = DATA_W-1 moves to DONE.
- DONE: lasts one cycle; done = 1, busy = 0; next state = IDLE.
- Timing: start accepted at edge 0; bits presented in cycles 1..DATA_W; done high in cycle DATA_W+1. A match on the last bit pulses in the same cycle as done.
- start while in SHIFT or DONE: ignored.
- start held high: a new scan is accepted at the first edge in IDLE, one cycle after done.
- Result hold: match_count, first_pos and found stay stable from done until the next accepted start.
- match_count cannot overflow (maximum DATA_W-PAT_W+1 ≤ 2^CNT_W-1).
- Reset mid-scan: async return to IDLE with all outputs 0; no done pulse; partial results discarded.

Decomposition:
- Shared package seq_scan_pkg holds:
  - state enum: IDLE = 2'b00, SHIFT = 2'b01, DONE = 2'b10;
  - a clog2-based width constant helper.
- One sub-module, pattern_match:
  - inputs: history, fill, bit, pattern;
  - output: hit (combinational compare plus fill qualification).
  - The FSM, counters and shift register stay in seq_scan_ctrl.

Test Plan:
- (DATA_W = 16, PAT_W = 4 unless stated.)
- data_in = 0xA5A5, pattern = 1010, overlap = 1 -> match pulses after idx 3 and 11; done in cycle 17; match_count = 2, first_pos = 3, found = 1.
- data_in = 0xAAAA, pattern = 1010: overlap = 1 -> match_count = 7 (idx 3, 5, …, 15); overlap = 0 -> match_count = 4 (idx 3, 7, 11, 15); first_pos = 3 in both.
- data_in = 0x0000, pattern = 1010 -> no match pulses; match_count = 0, found = 0, first_pos = 0; done exactly in cycle 17, busy high in cycles 1–16.
- data_in = 0xFFFF, pattern = 1111, overlap = 1 -> match_count = 13; final match pulse coincides with done; results held until the next start.
- reset driven 0 at cycle 8 of a scan -> busy, match, done and match_count go 0 immediately with no done pulse. After release, a start with 0xA5A5 completes with match_count = 2.
- start held high across two scans, with data_in changed during SHIFT -> the change is ignored. The second scan is accepted one cycle after the first done and uses data_in sampled at that edge.

Source files
------------

// File: rtl/seq_scan_pkg.sv
// Shared definitions for the serial scan controller: the FSM state
// encoding and a width helper for counters sized from a maximum value.
package seq_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } scan_state_t;

    // Bits needed to hold any value in 0..max_value (at least one bit).
    function automatic int count_width(input int max_value);
        if (max_value < 1) begin
            return 1;
        end
        return $clog2(max_value + 1);
    endfunction

endpackage

// File: rtl/seq_scan_ctrl_pattern_match.sv
// Combinational pattern matcher: the newest bit plus the PAT_W-1 bits of
// history form the candidate window. A hit is only reported once enough
// fresh bits have been seen since the window was last cleared.
module pattern_match #(
    parameter int PAT_W  = 4,
    parameter int FILL_W = 2
) (
    input  logic [PAT_W-2:0]  history,
    input  logic [FILL_W-1:0] fill,
    input  logic              bit_in,
    input  logic [PAT_W-1:0]  pattern,
    output logic              hit
);

    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W - 1);

    // Window compare, qualified by a full history.
    always_comb begin
        hit = (fill == FILL_FULL) && ({history, bit_in} == pattern);
    end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Self-timed scan controller: captures a word on start, presents it MSB
// first one bit per clock, runs each bit through the pattern matcher and
// keeps the match count and the position of the first match.
module seq_scan_ctrl
    import seq_scan_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int PAT_W  = 4,
    parameter int CNT_W  = count_width(DATA_W)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    input  logic [PAT_W-1:0]  pattern,
    input  logic              overlap,
    output logic              busy,
    output logic              bit_out,
    output logic              bit_valid,
    output logic              match,
    output logic              done,
    output logic              found,
    output logic [CNT_W-1:0]  match_count,
    output logic [CNT_W-1:0]  first_pos
);

    localparam int HIST_W = PAT_W - 1;
    localparam int FILL_W = count_width(PAT_W - 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W - 1);
    localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(DATA_W - 1);

    generate
        if (PAT_W < 2 || PAT_W > DATA_W) begin : g_bad_pat_w
            $error("seq_scan_ctrl: PAT_W must be in 2..DATA_W");
        end
    endgenerate

    scan_state_t state;
    scan_state_t state_next;

    logic [DATA_W-1:0] shift_reg;
    logic [PAT_W-1:0]  pat_reg;
    logic              ovl_reg;
    logic [HIST_W-1:0] history;
    logic [FILL_W-1:0] fill;
    logic [CNT_W-1:0]  idx;
    logic              hit;
    logic              shifting;
    logic              accept;

    assign shifting = (state == SHIFT);
    assign accept   = (state == IDLE) && start;

    pattern_match #(
        .PAT_W  (PAT_W),
        .FILL_W (FILL_W)
    ) u_match (
        .history (history),
        .fill    (fill),
        .bit_in  (shift_reg[DATA_W-1]),
        .pattern (pat_reg),
        .hit     (hit)
    );

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: a scan runs for exactly DATA_W bits, then one DONE cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (idx == LAST_IDX) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode from the current state.
    always_comb begin
        busy      = shifting;
        bit_valid = shifting;
        bit_out   = shifting & shift_reg[DATA_W-1];
        done      = (state == DONE);
    end

    // Datapath: capture on accept, shift and match while scanning, hold results otherwise.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shift_reg   <= '0;
            pat_reg     <= '0;
            ovl_reg     <= 1'b0;
            history     <= '0;
            fill        <= '0;
            idx         <= '0;
            match       <= 1'b0;
            found       <= 1'b0;
            match_count <= '0;
            first_pos   <= '0;
        end else begin
            match <= 1'b0;
            if (accept) begin
                shift_reg   <= data_in;
                pat_reg     <= pattern;
                ovl_reg     <= overlap;
                history     <= '0;
                fill        <= '0;
                idx         <= '0;
                found       <= 1'b0;
                match_count <= '0;
                first_pos   <= '0;
            end else if (shifting) begin
                shift_reg <= shift_reg << 1;
                idx       <= idx + CNT_W'(1);
                if (hit && !ovl_reg) begin
                    history <= '0;
                    fill    <= '0;
                end else begin
                    history <= HIST_W'({history, shift_reg[DATA_W-1]});
                    if (fill != FILL_FULL) begin
                        fill <= fill + FILL_W'(1);
                    end
                end
                if (hit) begin
                    match       <= 1'b1;
                    match_count <= match_count + CNT_W'(1);
                    if (!found) begin
                        found     <= 1'b1;
                        first_pos <= idx;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Directed bench for seq_scan_ctrl (DATA_W = 16, PAT_W = 4): table-driven
// scans plus hand-written sequences for hold, mid-scan reset and held start.
module tb_seq_scan_ctrl;

    localparam int DATA_W = 16;
    localparam int PAT_W  = 4;
    localparam int CNT_W  = 5;

    logic              clock;
    logic              reset;
    logic              start;
    logic [DATA_W-1:0] data_in;
    logic [PAT_W-1:0]  pattern;
    logic              overlap;
    logic              busy;
    logic              bit_out;
    logic              bit_valid;
    logic              match;
    logic              done;
    logic              found;
    logic [CNT_W-1:0]  match_count;
    logic [CNT_W-1:0]  first_pos;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [15:0] data;
        logic [3:0]  pat;
        logic        ovl;
        logic [15:0] mask;
        int          count;
        int          first;
        logic        fnd;
    } vec_t;

    vec_t vectors[7];

    seq_scan_ctrl #(
        .DATA_W (DATA_W),
        .PAT_W  (PAT_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .data_in     (data_in),
        .pattern     (pattern),
        .overlap     (overlap),
        .busy        (busy),
        .bit_out     (bit_out),
        .bit_valid   (bit_valid),
        .match       (match),
        .done        (done),
        .found       (found),
        .match_count (match_count),
        .first_pos   (first_pos)
    );

    // Free-running clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Watches cycles 1..17 after an accept edge, sampling on falling edges.
    task automatic monitorScan(output logic [15:0] obs_bits, output logic [15:0] obs_mask,
                               output int busy_cycles, output int done_cycle,
                               output int done_pulses, output int stray);
        obs_bits    = '0;
        obs_mask    = '0;
        busy_cycles = 0;
        done_cycle  = 0;
        done_pulses = 0;
        stray       = 0;
        for (int c = 1; c <= DATA_W + 1; c++) begin
            @(negedge clock);
            if (bit_valid != busy) stray++;
            if (busy) begin
                busy_cycles++;
                if (c <= DATA_W) obs_bits[DATA_W - c] = bit_out;
            end
            if (match) begin
                if (c >= 2) obs_mask[c - 2] = 1'b1;
                else stray++;
            end
            if (done) begin
                done_pulses++;
                done_cycle = c;
            end
        end
    endtask

    // Checks the whole scan that starts just after an accept edge, then the results in cycle 18.
    task automatic checkScan(input string tag, input logic [15:0] exp_data,
                             input logic [15:0] exp_mask, input int exp_count,
                             input int exp_first, input logic exp_found);
        logic [15:0] obs_bits;
        logic [15:0] obs_mask;
        int busy_cycles, done_cycle, done_pulses, stray;
        monitorScan(obs_bits, obs_mask, busy_cycles, done_cycle, done_pulses, stray);
        checkOutput({tag, ".bits"},        obs_bits, exp_data);
        checkOutput({tag, ".match_mask"},  obs_mask, exp_mask);
        checkOutput({tag, ".busy_cycles"}, busy_cycles, DATA_W);
        checkOutput({tag, ".done_cycle"},  done_cycle, DATA_W + 1);
        checkOutput({tag, ".done_pulses"}, done_pulses, 1);
        checkOutput({tag, ".stray"},       stray, 0);
        @(negedge clock);
        checkOutput({tag, ".count"}, match_count, exp_count);
        checkOutput({tag, ".first"}, first_pos, exp_first);
        checkOutput({tag, ".found"}, found, exp_found);
        checkOutput({tag, ".idle_busy"}, busy, 0);
        checkOutput({tag, ".idle_done"}, done, 0);
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clock);
        data_in = v.data;
        pattern = v.pat;
        overlap = v.ovl;
        start   = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        checkScan(v.name, v.data, v.mask, v.count, v.first, v.fnd);
    endtask

    initial begin
        int done_seen;
        int busy_seen;

        vectors[0] = '{"a5a5_1010_ov",  16'hA5A5, 4'b1010, 1'b1, 16'h0808,  2, 3, 1'b1};
        vectors[1] = '{"aaaa_1010_ov",  16'hAAAA, 4'b1010, 1'b1, 16'hAAA8,  7, 3, 1'b1};
        vectors[2] = '{"aaaa_1010_nov", 16'hAAAA, 4'b1010, 1'b0, 16'h8888,  4, 3, 1'b1};
        vectors[3] = '{"zero_1010",     16'h0000, 4'b1010, 1'b1, 16'h0000,  0, 0, 1'b0};
        vectors[4] = '{"ffff_1111_ov",  16'hFFFF, 4'b1111, 1'b1, 16'hFFF8, 13, 3, 1'b1};
        vectors[5] = '{"ffff_1111_nov", 16'hFFFF, 4'b1111, 1'b0, 16'h8888,  4, 3, 1'b1};
        vectors[6] = '{"6666_0011_ov",  16'h6666, 4'b0011, 1'b1, 16'h4440,  3, 6, 1'b1};

        reset   = 1'b0;
        start   = 1'b0;
        data_in = '0;
        pattern = '0;
        overlap = 1'b0;

        // Reset state.
        repeat (2) @(negedge clock);
        checkOutput("reset.busy",      busy, 0);
        checkOutput("reset.bit_valid", bit_valid, 0);
        checkOutput("reset.bit_out",   bit_out, 0);
        checkOutput("reset.match",     match, 0);
        checkOutput("reset.done",      done, 0);
        checkOutput("reset.found",     found, 0);
        checkOutput("reset.count",     match_count, 0);
        checkOutput("reset.first",     first_pos, 0);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vectors[i]);
            if (i == 4) begin
                repeat (5) @(negedge clock);
                checkOutput("hold.count", match_count, 13);
                checkOutput("hold.first", first_pos, 3);
                checkOutput("hold.found", found, 1);
                checkOutput("hold.done",  done, 0);
            end
        end

        // Reset in cycle 8 of a scan: everything drops at once, no done afterwards.
        @(negedge clock);
        data_in = 16'hA5A5;
        pattern = 4'b1010;
        overlap = 1'b1;
        start   = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (8) @(negedge clock);
        checkOutput("midrst.pre_count", match_count, 1);
        checkOutput("midrst.pre_busy",  busy, 1);
        #1 reset = 1'b0;
        #1;
        checkOutput("midrst.busy",  busy, 0);
        checkOutput("midrst.match", match, 0);
        checkOutput("midrst.done",  done, 0);
        checkOutput("midrst.count", match_count, 0);
        checkOutput("midrst.found", found, 0);
        @(negedge clock);
        reset     = 1'b1;
        done_seen = 0;
        busy_seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (done) done_seen++;
            if (busy) busy_seen++;
        end
        checkOutput("midrst.no_done", done_seen, 0);
        checkOutput("midrst.no_busy", busy_seen, 0);
        applyStimulus(vectors[0]);

        // Start held across two scans; data_in changes during SHIFT are ignored.
        @(negedge clock);
        data_in = 16'hA5A5;
        pattern = 4'b1010;
        overlap = 1'b1;
        start   = 1'b1;
        @(posedge clock);
        #1 data_in = 16'h1234;
        begin
            logic [15:0] obs_bits;
            logic [15:0] obs_mask;
            int busy_cycles, done_cycle, done_pulses, stray;
            monitorScan(obs_bits, obs_mask, busy_cycles, done_cycle, done_pulses, stray);
            checkOutput("held1.bits",       obs_bits, 16'hA5A5);
            checkOutput("held1.match_mask", obs_mask, 16'h0808);
            checkOutput("held1.done_cycle", done_cycle, DATA_W + 1);
        end
        @(negedge clock);
        checkOutput("held.gap_busy",  busy, 0);
        checkOutput("held.gap_count", match_count, 2);
        data_in = 16'hAAAA;
        @(posedge clock);
        #1 start = 1'b0;
        checkScan("held2", 16'hAAAA, 16'hAAA8, 7, 3, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: got running, expected finished");
        $fatal(1, "[TB] time limit reached");
    end

endmodule
